// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus arbiter and its holding slots.
package cpu_bus_pkg;

    // Width of the address field inside a held request.
    localparam int unsigned BUS_ADDR_WIDTH = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } owner_t;

    typedef struct packed {
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [1:0]                size;
        logic                      write;
        logic [31:0]               wdata;
    } bus_req_t;

endpackage

// File: rtl/cpu_bus_req_slot.sv
// One request holding slot: captures a request pulse, holds it until the
// owning port is acked, and flags requests that arrive while it is full.
module cpu_bus_req_slot
    import cpu_bus_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic [BUS_ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]                size_i,
    input  logic                      write_i,
    input  logic [31:0]               wdata_i,
    input  logic                      clear_i,
    output logic                      valid_o,
    output logic [BUS_ADDR_WIDTH-1:0] addr_o,
    output logic [1:0]                size_o,
    output logic                      write_o,
    output logic [31:0]               wdata_o,
    output logic                      overflow_o
);

    logic     valid_q, valid_d;
    bus_req_t req_q, req_d;
    logic     accept;

    // A load is accepted into an empty slot, or into one being cleared this cycle.
    assign accept     = load_i && (!valid_q || clear_i);
    assign overflow_o = load_i && valid_q && !clear_i;

    // Next-state: reload on accept, otherwise drop valid on clear.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (accept) begin
            valid_d     = 1'b1;
            req_d.addr  = addr_i;
            req_d.size  = size_i;
            req_d.write = write_i;
            req_d.wdata = wdata_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = req_q.addr;
    assign size_o  = req_q.size;
    assign write_o = req_q.write;
    assign wdata_o = req_q.wdata;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one memory bus between the CPU fetch port (cpui) and data port (cpud).
// One transaction outstanding at a time; acks and read data are routed back
// combinationally in the mem_ack cycle.
// Optional: define CPU_BUS_ARB_ROUND_ROBIN_EN to alternate grants when both
// ports are waiting; otherwise the data port always wins.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpui_request,
    input  logic [ADDR_WIDTH-1:0] cpui_addr,
    output logic [31:0]           cpui_rdata,
    output logic                  cpui_ack,
    input  logic                  cpud_request,
    input  logic [ADDR_WIDTH-1:0] cpud_addr,
    input  logic [1:0]            cpud_size,
    input  logic                  cpud_write,
    input  logic [31:0]           cpud_wdata,
    output logic [31:0]           cpud_rdata,
    output logic                  cpud_ack,
    output logic                  mem_request,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_size,
    output logic                  mem_write,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  protocol_error
);

    // The held-request struct has a fixed address width; the bus must match it.
    if (ADDR_WIDTH != BUS_ADDR_WIDTH) begin : g_width_check
        $error("cpu_bus_arbiter: ADDR_WIDTH must equal BUS_ADDR_WIDTH");
    end

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     grant;
    owner_t     sel;
    logic       drive;
    logic       protocol_error_q;

    logic                  instr_valid, instr_write, instr_overflow;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic [1:0]            instr_size;
    logic [31:0]           instr_wdata;

    logic                  data_valid, data_write, data_overflow;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [1:0]            data_size;
    logic [31:0]           data_wdata;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    owner_t last_grant_q, last_grant_d;
`endif

    // Fetches are always word reads.
    cpu_bus_req_slot u_instr_slot (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cpui_request),
        .addr_i     (cpui_addr),
        .size_i     (SIZE_WORD),
        .write_i    (1'b0),
        .wdata_i    (32'h0),
        .clear_i    (cpui_ack),
        .valid_o    (instr_valid),
        .addr_o     (instr_addr),
        .size_o     (instr_size),
        .write_o    (instr_write),
        .wdata_o    (instr_wdata),
        .overflow_o (instr_overflow)
    );

    cpu_bus_req_slot u_data_slot (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cpud_request),
        .addr_i     (cpud_addr),
        .size_i     (cpud_size),
        .write_i    (cpud_write),
        .wdata_i    (cpud_wdata),
        .clear_i    (cpud_ack),
        .valid_o    (data_valid),
        .addr_o     (data_addr),
        .size_o     (data_size),
        .write_o    (data_write),
        .wdata_o    (data_wdata),
        .overflow_o (data_overflow)
    );

    // Grant choice among valid slots.
    always_comb begin
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
        if (instr_valid && data_valid) begin
            grant = (last_grant_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end else begin
            grant = data_valid ? OWN_DATA : OWN_INSTR;
        end
`else
        grant = data_valid ? OWN_DATA : OWN_INSTR;
`endif
    end

    // FSM next-state, bus drive and ack routing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sel         = owner_q;
        drive       = 1'b0;
        mem_request = 1'b0;
        mem_addr    = '0;
        mem_size    = 2'b00;
        mem_write   = 1'b0;
        mem_wdata   = 32'h0;
        cpui_ack    = 1'b0;
        cpud_ack    = 1'b0;
        cpui_rdata  = 32'h0;
        cpud_rdata  = 32'h0;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                // mem_ack here is stray and deliberately ignored.
                if (instr_valid || data_valid) begin
                    sel         = grant;
                    drive       = 1'b1;
                    mem_request = 1'b1;
                    owner_d     = grant;
                    state_d     = WAIT;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant;
`endif
                end
            end
            WAIT: begin
                drive = 1'b1;
                if (mem_ack) begin
                    if (owner_q == OWN_DATA) begin
                        cpud_ack   = 1'b1;
                        cpud_rdata = mem_rdata;
                    end else begin
                        cpui_ack   = 1'b1;
                        cpui_rdata = mem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drive) begin
            if (sel == OWN_DATA) begin
                mem_addr  = data_addr;
                mem_size  = data_size;
                mem_write = data_write;
                mem_wdata = data_wdata;
            end else begin
                mem_addr  = instr_addr;
                mem_size  = instr_size;
                mem_write = instr_write;
                mem_wdata = instr_wdata;
            end
        end
    end

    // State, owner and sticky error registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            owner_q          <= OWN_INSTR;
            protocol_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (instr_overflow || data_overflow) begin
                protocol_error_q <= 1'b1;
            end
        end
    end

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    // Remembers the last granted port for alternation.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= OWN_INSTR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed self-checking bench for cpu_bus_arbiter.
module tb_cpu_bus_arbiter;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cpui_request;
    logic [31:0] cpui_addr;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request;
    logic [31:0] cpud_addr;
    logic [1:0]  cpud_size;
    logic        cpud_write;
    logic [31:0] cpud_wdata;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        protocol_error;

    int checks = 0;
    int failures = 0;
    int mem_req_count = 0;

    cpu_bus_arbiter #(.ADDR_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpui_request   (cpui_request),
        .cpui_addr      (cpui_addr),
        .cpui_rdata     (cpui_rdata),
        .cpui_ack       (cpui_ack),
        .cpud_request   (cpud_request),
        .cpud_addr      (cpud_addr),
        .cpud_size      (cpud_size),
        .cpud_write     (cpud_write),
        .cpud_wdata     (cpud_wdata),
        .cpud_rdata     (cpud_rdata),
        .cpud_ack       (cpud_ack),
        .mem_request    (mem_request),
        .mem_addr       (mem_addr),
        .mem_size       (mem_size),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .protocol_error (protocol_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_request === 1'b1) mem_req_count++;
    end

    // Advance one cycle and return all pulse inputs to idle.
    task automatic step();
        @(posedge clock);
        #1;
        cpui_request = 1'b0;
        cpud_request = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
    endtask

    // Settle combinational outputs after driving this cycle's inputs.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpui_request = 1'b0; cpui_addr = 32'h0;
        cpud_request = 1'b0; cpud_addr = 32'h0; cpud_size = 2'b00;
        cpud_write = 1'b0; cpud_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        reset = 1'b0;
        settle();
        checks++;
        if ({mem_request, mem_addr, mem_size, mem_write, mem_wdata} !== 68'h0) begin
            failures++;
            $display("FAIL reset_mem: got req=%0b addr=%h size=%0b want all zero",
                     mem_request, mem_addr, mem_size);
        end
        checks++;
        if ({cpui_ack, cpud_ack, cpui_rdata, cpud_rdata, protocol_error} !== 67'h0) begin
            failures++;
            $display("FAIL reset_cpu: got iack=%0b dack=%0b perr=%0b want 0",
                     cpui_ack, cpud_ack, protocol_error);
        end
    endtask

    task automatic test_single_fetch();
        int base;
        base = mem_req_count;
        step();
        cpui_request = 1'b1; cpui_addr = 32'h100;
        settle();
        checks++;
        if (mem_request !== 1'b0) begin
            failures++; $display("FAIL fetch_no_same_cycle: got %0b want 0", mem_request);
        end
        step();
        settle();
        checks++;
        if ({mem_request, mem_addr, mem_size, mem_write} !== {1'b1, 32'h100, 2'b10, 1'b0}) begin
            failures++;
            $display("FAIL fetch_issue: got req=%0b addr=%h size=%0b wr=%0b want 1 100 10 0",
                     mem_request, mem_addr, mem_size, mem_write);
        end
        step();
        settle();
        checks++;
        if ({mem_request, mem_addr, cpui_ack} !== {1'b0, 32'h100, 1'b0}) begin
            failures++;
            $display("FAIL fetch_wait: got req=%0b addr=%h ack=%0b want 0 100 0",
                     mem_request, mem_addr, cpui_ack);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        settle();
        checks++;
        if ({cpui_ack, cpui_rdata, cpud_ack, cpud_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL fetch_ack: got iack=%0b irdata=%h dack=%0b drdata=%h want 1 deadbeef 0 0",
                     cpui_ack, cpui_rdata, cpud_ack, cpud_rdata);
        end
        step();
        settle();
        checks++;
        if ({mem_request, cpui_ack, cpui_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL fetch_done: got req=%0b iack=%0b irdata=%h want 0 0 0",
                     mem_request, cpui_ack, cpui_rdata);
        end
        checks++;
        if (mem_req_count - base !== 1) begin
            failures++; $display("FAIL fetch_count: got %0d want 1", mem_req_count - base);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        logic [31:0] a1, a2;
        logic [1:0]  s1;
        logic        w1;
        // Data-only read first so a round-robin build remembers data as last grant.
        step();
        cpud_request = 1'b1; cpud_addr = 32'h700; cpud_size = 2'b10; cpud_write = 1'b0;
        cpud_wdata = 32'h0;
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        settle();
        checks++;
        if ({cpud_ack, cpud_rdata} !== {1'b1, 32'h0BADF00D}) begin
            failures++;
            $display("FAIL warm_ack: got dack=%0b drdata=%h want 1 0badf00d", cpud_ack, cpud_rdata);
        end
        base = mem_req_count;
        step();
        cpui_request = 1'b1; cpui_addr = 32'h104;
        cpud_request = 1'b1; cpud_addr = 32'h203; cpud_size = 2'b00; cpud_write = 1'b1;
        cpud_wdata = 32'hAA000000;
        a1 = RR ? 32'h104 : 32'h203;
        s1 = RR ? 2'b10 : 2'b00;
        w1 = RR ? 1'b0 : 1'b1;
        a2 = RR ? 32'h203 : 32'h104;
        step();
        settle();
        checks++;
        if ({mem_request, mem_addr, mem_size, mem_write} !== {1'b1, a1, s1, w1}) begin
            failures++;
            $display("FAIL sim_first: got req=%0b addr=%h size=%0b wr=%0b want 1 %h %0b %0b",
                     mem_request, mem_addr, mem_size, mem_write, a1, s1, w1);
        end
        checks++;
        if (mem_wdata !== (RR ? 32'h0 : 32'hAA000000)) begin
            failures++; $display("FAIL sim_first_wdata: got %h", mem_wdata);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        settle();
        checks++;
        if ({cpui_ack, cpud_ack} !== {RR, ~RR}) begin
            failures++;
            $display("FAIL sim_first_ack: got iack=%0b dack=%0b want %0b %0b",
                     cpui_ack, cpud_ack, RR, ~RR);
        end
        checks++;
        if (mem_request !== 1'b0) begin
            failures++; $display("FAIL sim_no_early_grant: got %0b want 0", mem_request);
        end
        step();
        settle();
        checks++;
        if ({mem_request, mem_addr} !== {1'b1, a2}) begin
            failures++;
            $display("FAIL sim_second: got req=%0b addr=%h want 1 %h", mem_request, mem_addr, a2);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        settle();
        checks++;
        if ({cpui_ack, cpud_ack} !== {~RR, RR}) begin
            failures++;
            $display("FAIL sim_second_ack: got iack=%0b dack=%0b want %0b %0b",
                     cpui_ack, cpud_ack, ~RR, RR);
        end
        step();
        settle();
        checks++;
        if (mem_req_count - base !== 2) begin
            failures++; $display("FAIL sim_count: got %0d want 2", mem_req_count - base);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = mem_req_count;
        step();
        cpud_request = 1'b1; cpud_addr = 32'h300; cpud_size = 2'b10; cpud_write = 1'b0;
        step();
        step();
        cpud_request = 1'b1; cpud_addr = 32'h400;
        settle();
        checks++;
        if (protocol_error !== 1'b0) begin
            failures++; $display("FAIL ovf_not_yet: got %0b want 0", protocol_error);
        end
        step();
        settle();
        checks++;
        if ({protocol_error, mem_addr} !== {1'b1, 32'h300}) begin
            failures++;
            $display("FAIL ovf_set: got perr=%0b addr=%h want 1 300", protocol_error, mem_addr);
        end
        step();
        mem_ack = 1'b1;
        settle();
        checks++;
        if (cpud_ack !== 1'b1) begin
            failures++; $display("FAIL ovf_ack: got %0b want 1", cpud_ack);
        end
        step();
        step();
        settle();
        checks++;
        if ({mem_request, protocol_error} !== {1'b0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_sticky: got req=%0b perr=%0b want 0 1", mem_request, protocol_error);
        end
        checks++;
        if (mem_req_count - base !== 1) begin
            failures++; $display("FAIL ovf_count: got %0d want 1", mem_req_count - base);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        settle();
        checks++;
        if (protocol_error !== 1'b0) begin
            failures++; $display("FAIL rst_clears_perr: got %0b want 0", protocol_error);
        end
        step();
        cpui_request = 1'b1; cpui_addr = 32'h500;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        checks++;
        if ({mem_request, mem_addr, mem_size, cpui_ack, cpud_ack} !== 37'h0) begin
            failures++;
            $display("FAIL rst_mid_idle: got req=%0b addr=%h size=%0b want 0",
                     mem_request, mem_addr, mem_size);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        settle();
        checks++;
        if ({cpui_ack, cpud_ack, cpui_rdata, cpud_rdata} !== 66'h0) begin
            failures++;
            $display("FAIL rst_late_ack: got iack=%0b dack=%0b irdata=%h want 0",
                     cpui_ack, cpud_ack, cpui_rdata);
        end
        step();
        settle();
        checks++;
        if (mem_request !== 1'b0) begin
            failures++; $display("FAIL rst_slot_cleared: got %0b want 0", mem_request);
        end
    endtask

    task automatic test_collision();
        step();
        cpud_request = 1'b1; cpud_addr = 32'h600; cpud_size = 2'b10; cpud_write = 1'b0;
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        cpud_request = 1'b1; cpud_addr = 32'h604; cpud_size = 2'b01;
        settle();
        checks++;
        if ({cpud_ack, cpud_rdata} !== {1'b1, 32'hCAFE0001}) begin
            failures++;
            $display("FAIL coll_ack: got dack=%0b drdata=%h want 1 cafe0001", cpud_ack, cpud_rdata);
        end
        step();
        settle();
        checks++;
        if ({mem_request, mem_addr, mem_size, protocol_error} !== {1'b1, 32'h604, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL coll_reissue: got req=%0b addr=%h size=%0b perr=%0b want 1 604 01 0",
                     mem_request, mem_addr, mem_size, protocol_error);
        end
        step();
        mem_ack = 1'b1;
        settle();
        checks++;
        if (cpud_ack !== 1'b1) begin
            failures++; $display("FAIL coll_second_ack: got %0b want 1", cpud_ack);
        end
        step();
        settle();
        checks++;
        if (protocol_error !== 1'b0) begin
            failures++; $display("FAIL coll_no_perr: got %0b want 0", protocol_error);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
